// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int N_LOG2_DEF = 6;
  localparam int RD_LAT_DEF = 1;
  localparam int OP_W       = 8;
  localparam int ACC_W      = 22;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Address is {row, col} of an N x N matrix, so twice the index width.
  function automatic int addrWidth(input int nLog2);
    return 2 * nLog2;
  endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Loop index counter {i,j,k} with k fastest; flags the final index combinationally.
module matmul_idx_cnt
  import matmul_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [N_LOG2-1:0] o_i,
  output logic [N_LOG2-1:0] o_j,
  output logic [N_LOG2-1:0] o_k,
  output logic              o_terminal
);

  localparam int CW = 3 * N_LOG2;

  logic [CW-1:0] r_count;

  // Clear has priority so a fresh job always starts from {0,0,0}.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign {o_i, o_j, o_k} = r_count;
  assign o_terminal      = &r_count;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matrix-multiply datapath: walks {i,j,k}, issues A/B reads,
// and aligns MAC and C write strobes to the operand RAM read latency.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter  int N_LOG2 = N_LOG2_DEF,
  parameter  int RD_LAT = RD_LAT_DEF,
  localparam int AW     = addrWidth(N_LOG2)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          ab_nce,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_load,
  output logic          mac_acc,
  output logic          c_nce,
  output logic          c_nwrt,
  output logic [AW-1:0] c_addr
);

  state_t r_state;
  state_t w_nextState;

  logic              r_startArm;
  logic [1:0]        r_drainCnt;
  logic              w_accept;
  logic              w_flush;
  logic              w_issue;
  logic              w_terminal;
  logic              w_drainLast;
  logic              w_kZero;
  logic              w_kLast;
  logic [N_LOG2-1:0] w_i;
  logic [N_LOG2-1:0] w_j;
  logic [N_LOG2-1:0] w_k;

  logic              r_pVld [RD_LAT];
  logic              r_pK0  [RD_LAT];
  logic              r_pKl  [RD_LAT];
  logic [N_LOG2-1:0] r_pI   [RD_LAT];
  logic [N_LOG2-1:0] r_pJ   [RD_LAT];
  logic              r_wrValid;
  logic [N_LOG2-1:0] r_wrI;
  logic [N_LOG2-1:0] r_wrJ;

  assign w_issue     = (r_state == RUN);
  assign w_kZero     = (w_k == '0);
  assign w_kLast     = &w_k;
  assign w_drainLast = (r_drainCnt == 2'(RD_LAT));

  matmul_idx_cnt #(
    .N_LOG2(N_LOG2)
  ) u_idxCnt (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (r_state != RUN),
    .i_enable  ((r_state == RUN) && !w_terminal),
    .o_i       (w_i),
    .o_j       (w_j),
    .o_k       (w_k),
    .o_terminal(w_terminal)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; abort only matters once a job is running.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ab_nce      = 1'b1;
    w_accept    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && r_startArm) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        ab_nce = 1'b0;
        if (abort) begin
          w_flush     = 1'b1;
          w_nextState = IDLE;
        end else if (w_terminal) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          w_flush     = 1'b1;
          w_nextState = IDLE;
        end else if (w_drainLast) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A held-high start counts once: it must drop before another job can be accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_startArm <= 1'b1;
    end else if (!start) begin
      r_startArm <= 1'b1;
    end else if (w_accept) begin
      r_startArm <= 1'b0;
    end
  end

  // Drain lasts RD_LAT+1 cycles so the final C write leaves the pipe before DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drainCnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drainCnt <= r_drainCnt + 2'd1;
    end else begin
      r_drainCnt <= '0;
    end
  end

  // Strobe pipe: RD_LAT stages feed the MAC, one more stage times the C write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_pVld[s] <= 1'b0;
        r_pK0[s]  <= 1'b0;
        r_pKl[s]  <= 1'b0;
        r_pI[s]   <= '0;
        r_pJ[s]   <= '0;
      end
      r_wrValid <= 1'b0;
      r_wrI     <= '0;
      r_wrJ     <= '0;
    end else if (w_flush) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_pVld[s] <= 1'b0;
        r_pK0[s]  <= 1'b0;
        r_pKl[s]  <= 1'b0;
        r_pI[s]   <= '0;
        r_pJ[s]   <= '0;
      end
      r_wrValid <= 1'b0;
      r_wrI     <= '0;
      r_wrJ     <= '0;
    end else begin
      r_pVld[0] <= w_issue;
      r_pK0[0]  <= w_kZero;
      r_pKl[0]  <= w_kLast;
      r_pI[0]   <= w_i;
      r_pJ[0]   <= w_j;
      for (int s = 1; s < RD_LAT; s++) begin
        r_pVld[s] <= r_pVld[s-1];
        r_pK0[s]  <= r_pK0[s-1];
        r_pKl[s]  <= r_pKl[s-1];
        r_pI[s]   <= r_pI[s-1];
        r_pJ[s]   <= r_pJ[s-1];
      end
      r_wrValid <= r_pVld[RD_LAT-1] & r_pKl[RD_LAT-1];
      if (r_pVld[RD_LAT-1] & r_pKl[RD_LAT-1]) begin
        r_wrI <= r_pI[RD_LAT-1];
        r_wrJ <= r_pJ[RD_LAT-1];
      end
    end
  end

  assign a_addr   = {w_i, w_k};
  assign b_addr   = {w_k, w_j};
  assign mac_load = r_pVld[RD_LAT-1] & r_pK0[RD_LAT-1];
  assign mac_acc  = r_pVld[RD_LAT-1] & ~r_pK0[RD_LAT-1];
  assign c_nce    = ~r_wrValid;
  assign c_nwrt   = ~r_wrValid;
  assign c_addr   = {r_wrI, r_wrJ};

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: two N=4 sequencers (read latency 1 and 3) drive
// behavioural operand RAMs, a MAC and a result RAM; results and timing are
// compared against a plain matrix product and the expected job timeline.
module tb_matmul_seq_ctrl;

  localparam int N   = 4;
  localparam int NN  = 16;
  localparam int NNN = 64;
  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  logic rstn;
  logic start [2];
  logic abort [2];
  logic busy [2];
  logic done [2];
  logic abNce [2];
  logic macLoad [2];
  logic macAcc [2];
  logic cNce [2];
  logic cNwrt [2];
  logic [3:0] aAddr [2];
  logic [3:0] bAddr [2];
  logic [3:0] cAddr [2];

  logic [7:0] memA [2][16];
  logic [7:0] memB [2][16];
  logic [7:0] aP [2][3];
  logic [7:0] bP [2][3];
  int acc [2];
  int memC [2][16];
  int cycle = 0;
  int wrAddrQ [2][$];
  int wrCycQ [2][$];
  int k0Q [2][$];
  int loadQ [2][$];
  int doneCnt [2] = '{0, 0};
  int doneCyc [2] = '{0, 0};
  int accCnt [2] = '{0, 0};
  int bothCnt [2] = '{0, 0};
  int issueCnt [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.N_LOG2(2), .RD_LAT(1)) dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .ab_nce(abNce[0]),
    .a_addr(aAddr[0]), .b_addr(bAddr[0]),
    .mac_load(macLoad[0]), .mac_acc(macAcc[0]),
    .c_nce(cNce[0]), .c_nwrt(cNwrt[0]), .c_addr(cAddr[0])
  );

  matmul_seq_ctrl #(.N_LOG2(2), .RD_LAT(3)) dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .ab_nce(abNce[1]),
    .a_addr(aAddr[1]), .b_addr(bAddr[1]),
    .mac_load(macLoad[1]), .mac_acc(macAcc[1]),
    .c_nce(cNce[1]), .c_nwrt(cNwrt[1]), .c_addr(cAddr[1])
  );

  // Behavioural RAMs and MAC, plus a log of every strobe with its cycle number.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    for (int g = 0; g < 2; g++) begin
      for (int s = 2; s > 0; s--) begin
        aP[g][s] <= aP[g][s-1];
        bP[g][s] <= bP[g][s-1];
      end
      aP[g][0] <= abNce[g] ? 8'h00 : memA[g][aAddr[g]];
      bP[g][0] <= abNce[g] ? 8'h00 : memB[g][bAddr[g]];
      if (!abNce[g]) begin
        issueCnt[g] <= issueCnt[g] + 1;
        if (aAddr[g][1:0] == 2'd0) k0Q[g].push_back(cycle);
      end
      if (macLoad[g]) begin
        acc[g] <= int'(aP[g][LAT[g]-1]) * int'(bP[g][LAT[g]-1]);
        loadQ[g].push_back(cycle);
      end else if (macAcc[g]) begin
        acc[g] <= acc[g] + int'(aP[g][LAT[g]-1]) * int'(bP[g][LAT[g]-1]);
      end
      if (macAcc[g]) accCnt[g] <= accCnt[g] + 1;
      if (macLoad[g] && macAcc[g]) bothCnt[g] <= bothCnt[g] + 1;
      if (!cNce[g] && !cNwrt[g]) begin
        memC[g][cAddr[g]] <= acc[g];
        wrAddrQ[g].push_back(int'(cAddr[g]));
        wrCycQ[g].push_back(cycle);
      end
      if (done[g]) begin
        doneCnt[g] <= doneCnt[g] + 1;
        doneCyc[g] <= cycle;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkReset(input int g);
    checkOutput($sformatf("rst%0d.busy", g), 32'(busy[g]), 0);
    checkOutput($sformatf("rst%0d.done", g), 32'(done[g]), 0);
    checkOutput($sformatf("rst%0d.abNce", g), 32'(abNce[g]), 1);
    checkOutput($sformatf("rst%0d.cNce", g), 32'(cNce[g]), 1);
    checkOutput($sformatf("rst%0d.cNwrt", g), 32'(cNwrt[g]), 1);
    checkOutput($sformatf("rst%0d.macLoad", g), 32'(macLoad[g]), 0);
    checkOutput($sformatf("rst%0d.macAcc", g), 32'(macAcc[g]), 0);
    checkOutput($sformatf("rst%0d.aAddr", g), 32'(aAddr[g]), 0);
    checkOutput($sformatf("rst%0d.bAddr", g), 32'(bAddr[g]), 0);
    checkOutput($sformatf("rst%0d.cAddr", g), 32'(cAddr[g]), 0);
  endtask

  // dataMode: 0 A=identity/B random, 1 all 255, 2 all random.
  // startStyle: 0 pulse, 1 held through job, 2 extra pulse mid-run, 3 start with abort.
  // abortAt: RUN-relative cycle to assert abort, or -1 for none.
  task automatic applyStimulus(input int g, input int dataMode, input int startStyle, input int abortAt);
    int s, L, n, nw, wr0, ld0, k00, iss0, acc0, both0, done0;
    int expC [16];
    L = LAT[g];
    for (int idx = 0; idx < NN; idx++) begin
      case (dataMode)
        0: begin
          memA[g][idx] = ((idx / N) == (idx % N)) ? 8'd1 : 8'd0;
          memB[g][idx] = 8'($urandom_range(0, 255));
        end
        1: begin
          memA[g][idx] = 8'd255;
          memB[g][idx] = 8'd255;
        end
        default: begin
          memA[g][idx] = 8'($urandom_range(0, 255));
          memB[g][idx] = 8'($urandom_range(0, 255));
        end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        expC[i*N+j] = 0;
        for (int k = 0; k < N; k++) expC[i*N+j] += int'(memA[g][i*N+k]) * int'(memB[g][k*N+j]);
      end
    end
    wr0 = wrAddrQ[g].size();
    ld0 = loadQ[g].size();
    k00 = k0Q[g].size();
    iss0 = issueCnt[g];
    acc0 = accCnt[g];
    both0 = bothCnt[g];
    done0 = doneCnt[g];

    @(negedge clk);
    s = cycle;
    start[g] = 1'b1;
    abort[g] = (startStyle == 3);
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (startStyle != 1) start[g] = (startStyle == 2) && (n + 1 == 10);
      abort[g] = (abortAt > 0) && (n + 1 == abortAt);
      if (abortAt > 0 && n == abortAt) break;
      if (doneCnt[g] != done0) break;
    end

    if (abortAt > 0) begin
      checkOutput("abortBusy", 32'(busy[g]), 0);
      checkOutput("abortMac", 32'(macLoad[g] | macAcc[g]), 0);
      checkOutput("abortCnce", 32'(cNce[g]), 1);
      repeat (100) @(negedge clk);
      checkOutput("abortNoDone", 32'(doneCnt[g] - done0), 0);
      nw = 0;
      for (int c = N + L + 1; c <= abortAt; c += N) nw++;
      checkOutput("abortWrites", 32'(wrAddrQ[g].size() - wr0), 32'(nw));
      return;
    end

    checkOutput("doneSeen", 32'(doneCnt[g] - done0), 1);
    checkOutput("doneLatency", 32'(doneCyc[g] - s), 32'(1 + NNN + L + 1));
    repeat (6) @(negedge clk);
    checkOutput("idleAfter", 32'(busy[g]), 0);
    checkOutput("singleDone", 32'(doneCnt[g] - done0), 1);
    start[g] = 1'b0;
    checkOutput("issues", 32'(issueCnt[g] - iss0), NNN);
    checkOutput("accStrobes", 32'(accCnt[g] - acc0), NNN - NN);
    checkOutput("bothStrobes", 32'(bothCnt[g] - both0), 0);
    checkOutput("wrCount", 32'(wrAddrQ[g].size() - wr0), NN);
    checkOutput("loadCount", 32'(loadQ[g].size() - ld0), NN);
    for (int m = 0; m < NN; m++) begin
      if (wr0 + m < wrAddrQ[g].size()) begin
        checkOutput($sformatf("wrAddr[%0d]", m), 32'(wrAddrQ[g][wr0+m]), 32'(m));
        checkOutput($sformatf("wrCycle[%0d]", m), 32'(wrCycQ[g][wr0+m] - s), 32'(N + L + 1 + N * m));
      end
      checkOutput($sformatf("cVal[%0d]", m), 32'(memC[g][m]), 32'(expC[m]));
      if (ld0 + m < loadQ[g].size() && k00 + m < k0Q[g].size())
        checkOutput($sformatf("loadLag[%0d]", m), 32'(loadQ[g][ld0+m] - k0Q[g][k00+m]), 32'(L));
    end
  endtask

  initial begin
    int r;
    rstn = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      abort[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkReset(0);
    checkReset(1);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] identity A, latency 1");
    applyStimulus(0, 0, 0, -1);
    $display("[TB] saturated operands");
    applyStimulus(0, 1, 0, -1);
    $display("[TB] latency 3");
    applyStimulus(1, 0, 0, -1);
    applyStimulus(1, 2, 0, -1);

    $display("[TB] abort mid-job then clean restart");
    applyStimulus(0, 2, 0, 20);
    applyStimulus(0, 0, 0, -1);
    applyStimulus(0, 2, 0, $urandom_range(2, 66));
    applyStimulus(1, 2, 0, $urandom_range(2, 68));
    applyStimulus(1, 2, 0, -1);

    $display("[TB] async reset mid-run");
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    r = $urandom_range(5, 50);
    repeat (r) @(negedge clk);
    #2 rstn = 1'b0;
    #1 checkReset(0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    applyStimulus(0, 2, 0, -1);

    $display("[TB] start handshake corner cases");
    applyStimulus(0, 2, 1, -1);
    applyStimulus(0, 2, 2, -1);
    applyStimulus(0, 0, 3, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
